// File: rtl/vga_timing_gen_if.sv
// Pixel-timing bundle between the VGA timing generator and its consumer.
// en is driven by the consumer and freezes all timing while low; p_tick, line_start and frame_start are one-clk strobes.
interface vga_timing_if #(
  parameter int CW = 10
);
  logic          en;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic          p_tick;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  en,
    output hsync, vsync, video_on, p_tick, x, y, line_start, frame_start
  );

  modport slave (
    output en,
    input  hsync, vsync, video_on, p_tick, x, y, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, x/y scan counters, and syncs aligned with x/y.
// The region order is display, front porch, sync, back porch.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CLK_DIV   = 2,
  parameter int CW        = 10
) (
  input logic         clk,
  input logic         reset,
  vga_timing_if.master bus
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_DISPLAY);
  localparam logic [CW-1:0] V_VIS    = CW'(V_DISPLAY);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div_nxt;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic [CW-1:0] w_x_nxt;
  logic [CW-1:0] w_y_nxt;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_video_on;
  logic          w_p_tick;
  logic          w_x_wrap;
  logic          w_y_wrap;

  // p_tick is gated by reset so no strobe escapes in the reset clk, even with CLK_DIV=1.
  always_comb begin
    w_p_tick  = bus.en && !reset && (r_div == DIV_LAST);
    w_x_wrap  = (r_x == H_LAST);
    w_y_wrap  = (r_y == V_LAST);
    w_div_nxt = r_div;
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    if (bus.en) begin
      w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    end
    if (w_p_tick) begin
      w_x_nxt = w_x_wrap ? '0 : r_x + 1'b1;
      if (w_x_wrap) begin
        w_y_nxt = w_y_wrap ? '0 : r_y + 1'b1;
      end
    end
  end

  // Syncs and video_on are decoded from the next x/y so they land in the same clk as the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_video_on <= 1'b1;
      r_hsync    <= ~HSYNC_POL;
      r_vsync    <= ~VSYNC_POL;
    end else begin
      r_div      <= w_div_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_video_on <= (w_x_nxt < H_VIS) && (w_y_nxt < V_VIS);
      r_hsync    <= ((w_x_nxt >= HS_BEG) && (w_x_nxt <= HS_END)) ? HSYNC_POL : ~HSYNC_POL;
      r_vsync    <= ((w_y_nxt >= VS_BEG) && (w_y_nxt <= VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    end
  end

  assign bus.p_tick      = w_p_tick;
  assign bus.line_start  = w_p_tick && w_x_wrap;
  assign bus.frame_start = w_p_tick && w_x_wrap && w_y_wrap;
  assign bus.x           = r_x;
  assign bus.y           = r_y;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.video_on    = r_video_on;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small 8x6 raster (CLK_DIV 2 and 1, both sync polarities) and one line of 640x480.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  vga_timing_if #(.CW(10)) bus_a();
  vga_timing_if #(.CW(10)) bus_b();
  vga_timing_if #(.CW(10)) bus_c();

  vga_timing_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(2), .CW(10)
  ) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));

  vga_timing_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(1), .CW(10)
  ) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  vga_timing_gen dut_c (.clk(clk), .reset(rst_c), .bus(bus_c));

  task automatic test_reset();
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    bus_a.en = 1'b1; bus_b.en = 1'b1; bus_c.en = 1'b1;
    @(negedge clk); #1;
    total++; if (bus_a.x !== 10'd0 || bus_a.y !== 10'd0) begin bad++; $display("FAIL rst_a_xy got=%0d,%0d exp=0,0", bus_a.x, bus_a.y); end
    total++; if (bus_a.video_on !== 1'b1) begin bad++; $display("FAIL rst_a_video got=%b exp=1", bus_a.video_on); end
    total++; if (bus_a.hsync !== 1'b1 || bus_a.vsync !== 1'b1) begin bad++; $display("FAIL rst_a_sync got=%b%b exp=11", bus_a.hsync, bus_a.vsync); end
    total++; if ({bus_a.p_tick, bus_a.line_start, bus_a.frame_start} !== 3'b000) begin bad++; $display("FAIL rst_a_strobes got=%b%b%b exp=000", bus_a.p_tick, bus_a.line_start, bus_a.frame_start); end
    total++; if (bus_b.hsync !== 1'b0 || bus_b.vsync !== 1'b0) begin bad++; $display("FAIL rst_b_sync got=%b%b exp=00", bus_b.hsync, bus_b.vsync); end
    total++; if (bus_b.p_tick !== 1'b0) begin bad++; $display("FAIL rst_b_ptick got=%b exp=0", bus_b.p_tick); end
    total++; if (bus_c.hsync !== 1'b1 || bus_c.video_on !== 1'b1 || bus_c.x !== 10'd0) begin bad++; $display("FAIL rst_c got hs=%b vid=%b x=%0d exp hs=1 vid=1 x=0", bus_c.hsync, bus_c.video_on, bus_c.x); end
    @(negedge clk); #1;
    total++; if (bus_a.x !== 10'd0 || bus_b.x !== 10'd0) begin bad++; $display("FAIL rst_hold got=%0d,%0d exp=0,0", bus_a.x, bus_b.x); end
  endtask

  task automatic test_small_frame();
    logic [9:0] mx, my;
    logic mdiv, tk, e_hs, e_vs, e_vid;
    int fs_n;
    mx = '0; my = '0; mdiv = 1'b0; fs_n = 0;
    @(negedge clk); rst_a = 1'b1; bus_a.en = 1'b1;
    @(negedge clk); rst_a = 1'b0; #1;
    for (int c = 0; c < 96; c++) begin
      tk    = mdiv;
      e_hs  = !(mx >= 10'd5 && mx <= 10'd6);
      e_vs  = (my != 10'd4);
      e_vid = (mx < 10'd4) && (my < 10'd3);
      total++; if (bus_a.x !== mx || bus_a.y !== my) begin bad++; $display("FAIL frame_xy c=%0d got=%0d,%0d exp=%0d,%0d", c, bus_a.x, bus_a.y, mx, my); end
      total++; if (bus_a.hsync !== e_hs) begin bad++; $display("FAIL frame_hsync c=%0d got=%b exp=%b", c, bus_a.hsync, e_hs); end
      total++; if (bus_a.vsync !== e_vs) begin bad++; $display("FAIL frame_vsync c=%0d got=%b exp=%b", c, bus_a.vsync, e_vs); end
      total++; if (bus_a.video_on !== e_vid) begin bad++; $display("FAIL frame_video c=%0d got=%b exp=%b", c, bus_a.video_on, e_vid); end
      total++; if (bus_a.p_tick !== tk) begin bad++; $display("FAIL frame_ptick c=%0d got=%b exp=%b", c, bus_a.p_tick, tk); end
      total++; if (bus_a.line_start !== (tk && mx == 10'd7)) begin bad++; $display("FAIL frame_ls c=%0d got=%b", c, bus_a.line_start); end
      total++; if (bus_a.frame_start !== (tk && mx == 10'd7 && my == 10'd5)) begin bad++; $display("FAIL frame_fs c=%0d got=%b", c, bus_a.frame_start); end
      if (bus_a.frame_start === 1'b1) fs_n++;
      if (tk) begin
        if (mx == 10'd7) begin mx = '0; my = (my == 10'd5) ? 10'd0 : my + 10'd1; end
        else mx = mx + 10'd1;
      end
      mdiv = ~mdiv;
      @(negedge clk); #1;
    end
    total++; if (bus_a.x !== 10'd0 || bus_a.y !== 10'd0 || bus_a.p_tick !== 1'b0) begin bad++; $display("FAIL frame_period got x=%0d y=%0d pt=%b exp 0 0 0", bus_a.x, bus_a.y, bus_a.p_tick); end
    total++; if (fs_n != 1) begin bad++; $display("FAIL frame_fs_count got=%0d exp=1", fs_n); end
  endtask

  task automatic test_en_pause();
    logic [9:0] mx, my;
    logic mdiv, tk, en_v;
    int fs_c;
    mx = '0; my = '0; mdiv = 1'b0; en_v = 1'b1; fs_c = -1;
    @(negedge clk); rst_a = 1'b1; bus_a.en = 1'b1;
    @(negedge clk); rst_a = 1'b0; #1;
    for (int c = 0; c < 103; c++) begin
      tk = en_v && mdiv;
      total++; if (bus_a.x !== mx || bus_a.y !== my) begin bad++; $display("FAIL pause_xy c=%0d got=%0d,%0d exp=%0d,%0d", c, bus_a.x, bus_a.y, mx, my); end
      total++; if (bus_a.p_tick !== tk) begin bad++; $display("FAIL pause_ptick c=%0d got=%b exp=%b", c, bus_a.p_tick, tk); end
      if (bus_a.frame_start === 1'b1) fs_c = c;
      if (tk) begin
        if (mx == 10'd7) begin mx = '0; my = (my == 10'd5) ? 10'd0 : my + 10'd1; end
        else mx = mx + 10'd1;
      end
      if (en_v) mdiv = ~mdiv;
      @(negedge clk);
      en_v = !((c + 1) >= 7 && (c + 1) < 14);
      bus_a.en = en_v;
      #1;
    end
    total++; if (bus_a.x !== 10'd0 || bus_a.y !== 10'd0 || bus_a.p_tick !== 1'b0) begin bad++; $display("FAIL pause_period got x=%0d y=%0d pt=%b exp 0 0 0", bus_a.x, bus_a.y, bus_a.p_tick); end
    total++; if (fs_c != 102) begin bad++; $display("FAIL pause_fs_cycle got=%0d exp=102", fs_c); end
  endtask

  task automatic test_reset_mid();
    int ls_n, fs_n;
    ls_n = 0; fs_n = 0;
    @(negedge clk); rst_a = 1'b1; bus_a.en = 1'b1;
    @(negedge clk); rst_a = 1'b0;
    repeat (44) @(negedge clk);
    #1;
    total++; if (bus_a.x !== 10'd6 || bus_a.y !== 10'd2) begin bad++; $display("FAIL mid_pre got=%0d,%0d exp=6,2", bus_a.x, bus_a.y); end
    rst_a = 1'b1;
    @(negedge clk); #1;
    total++; if (bus_a.x !== 10'd0 || bus_a.y !== 10'd0 || bus_a.video_on !== 1'b1) begin bad++; $display("FAIL mid_rst got x=%0d y=%0d vid=%b exp 0 0 1", bus_a.x, bus_a.y, bus_a.video_on); end
    total++; if (bus_a.hsync !== 1'b1 || bus_a.vsync !== 1'b1) begin bad++; $display("FAIL mid_rst_sync got=%b%b exp=11", bus_a.hsync, bus_a.vsync); end
    rst_a = 1'b0;
    #1;
    for (int c = 0; c < 96; c++) begin
      total++; if (bus_a.line_start !== (c % 16 == 15)) begin bad++; $display("FAIL mid_ls c=%0d got=%b", c, bus_a.line_start); end
      total++; if (bus_a.frame_start !== (c == 95)) begin bad++; $display("FAIL mid_fs c=%0d got=%b", c, bus_a.frame_start); end
      if (bus_a.line_start === 1'b1) ls_n++;
      if (bus_a.frame_start === 1'b1) fs_n++;
      @(negedge clk); #1;
    end
    total++; if (ls_n != 6 || fs_n != 1) begin bad++; $display("FAIL mid_counts got ls=%0d fs=%0d exp ls=6 fs=1", ls_n, fs_n); end
  endtask

  task automatic test_pol_div1();
    logic [9:0] mx, my;
    logic en_v, e_hs, e_vs;
    mx = '0; my = '0; en_v = 1'b1;
    @(negedge clk); rst_b = 1'b1; bus_b.en = 1'b1;
    @(negedge clk); rst_b = 1'b0; #1;
    for (int c = 0; c < 60; c++) begin
      e_hs = (mx >= 10'd5 && mx <= 10'd6);
      e_vs = (my == 10'd4);
      total++; if (bus_b.x !== mx || bus_b.y !== my) begin bad++; $display("FAIL div1_xy c=%0d got=%0d,%0d exp=%0d,%0d", c, bus_b.x, bus_b.y, mx, my); end
      total++; if (bus_b.hsync !== e_hs || bus_b.vsync !== e_vs) begin bad++; $display("FAIL pol_sync c=%0d got=%b%b exp=%b%b", c, bus_b.hsync, bus_b.vsync, e_hs, e_vs); end
      total++; if (bus_b.p_tick !== en_v) begin bad++; $display("FAIL div1_ptick c=%0d got=%b exp=%b", c, bus_b.p_tick, en_v); end
      total++; if (bus_b.frame_start !== (c == 47)) begin bad++; $display("FAIL div1_fs c=%0d got=%b", c, bus_b.frame_start); end
      if (c == 48) begin
        total++; if (bus_b.x !== 10'd0 || bus_b.y !== 10'd0) begin bad++; $display("FAIL div1_period got=%0d,%0d exp=0,0", bus_b.x, bus_b.y); end
      end
      if (en_v) begin
        if (mx == 10'd7) begin mx = '0; my = (my == 10'd5) ? 10'd0 : my + 10'd1; end
        else mx = mx + 10'd1;
      end
      @(negedge clk);
      en_v = ((c + 1) < 48) || ((c + 1) % 3 != 0);
      bus_b.en = en_v;
      #1;
    end
  endtask

  task automatic test_default_line();
    logic [9:0] mx, my;
    logic mdiv, tk, e_hs, e_vid;
    mx = '0; my = '0; mdiv = 1'b0;
    @(negedge clk); rst_c = 1'b1; bus_c.en = 1'b1;
    @(negedge clk); rst_c = 1'b0; #1;
    for (int c = 0; c <= 1600; c++) begin
      tk    = mdiv;
      e_hs  = !(mx >= 10'd656 && mx <= 10'd751);
      e_vid = (mx < 10'd640) && (my < 10'd480);
      total++; if (bus_c.x !== mx || bus_c.y !== my) begin bad++; $display("FAIL dflt_xy c=%0d got=%0d,%0d exp=%0d,%0d", c, bus_c.x, bus_c.y, mx, my); end
      total++; if (bus_c.hsync !== e_hs) begin bad++; $display("FAIL dflt_hsync c=%0d got=%b exp=%b", c, bus_c.hsync, e_hs); end
      total++; if (bus_c.video_on !== e_vid) begin bad++; $display("FAIL dflt_video c=%0d got=%b exp=%b", c, bus_c.video_on, e_vid); end
      total++; if (bus_c.line_start !== (tk && mx == 10'd799)) begin bad++; $display("FAIL dflt_ls c=%0d got=%b", c, bus_c.line_start); end
      if (c == 1600) begin
        total++; if (bus_c.x !== 10'd0 || bus_c.y !== 10'd1) begin bad++; $display("FAIL dflt_line_period got=%0d,%0d exp=0,1", bus_c.x, bus_c.y); end
      end
      if (tk) begin
        if (mx == 10'd799) begin mx = '0; my = my + 10'd1; end
        else mx = mx + 10'd1;
      end
      mdiv = ~mdiv;
      @(negedge clk); #1;
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    bus_a.en = 1'b0; bus_b.en = 1'b0; bus_c.en = 1'b0;
    test_reset();
    test_small_frame();
    test_en_pause();
    test_reset_mid();
    test_pol_div1();
    test_default_line();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL provide parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 SHALL provide parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 SHALL provide parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL provide parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 SHALL provide parameters V_DISPLAY, V_FRONT, V_SYNC, V_BACK, defaults 480, 10, 2, 33, the vertical equivalents in lines.
REQ-006 SHALL provide parameters HSYNC_POL and VSYNC_POL, default 0 each; 0 = active-low sync, 1 = active-high sync.
REQ-007 SHALL provide parameter CLK_DIV, default 2 (legal >= 1), giving clk cycles per pixel.
REQ-008 SHALL provide parameter CW, default 10, as the width of the x and y outputs; H_TOTAL-1 and V_TOTAL-1 SHALL fit in CW bits.
REQ-009 SHALL have port clk, input, 1 bit, the single clock.
REQ-010 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-011 SHALL have port en, input, 1 bit; when low, the timing freezes.
REQ-012 SHALL have port hsync, output, 1 bit, horizontal sync at HSYNC_POL polarity.
REQ-013 SHALL have port vsync, output, 1 bit, vertical sync at VSYNC_POL polarity.
REQ-014 SHALL have port video_on, output, 1 bit, high inside the visible area.
REQ-015 SHALL have port p_tick, output, 1 bit, one-clk pixel-advance strobe.
REQ-016 SHALL have ports x and y, outputs, CW bits each, the current pixel column and line.
REQ-017 SHALL have ports line_start and frame_start, outputs, 1 bit each, single-clk strobes.

Function
REQ-018 SHALL define H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK and V_TOTAL as the vertical equivalent; region order SHALL be display, front porch, sync, back porch.
REQ-019 SHALL run a divider counter 0..CLK_DIV-1 that advances only while en=1; p_tick SHALL be 1 in the clk where divider = CLK_DIV-1 and en=1; with CLK_DIV=1, p_tick SHALL equal en.
REQ-020 SHALL advance x by 1 on every clk edge with p_tick=1, wrapping H_TOTAL-1 -> 0.
REQ-021 SHALL advance y by 1 only on the edge where p_tick=1 and x=H_TOTAL-1, wrapping V_TOTAL-1 -> 0 (x and y wrap on the same edge at end of frame).
REQ-022 SHALL keep the divider, x and y unchanged while en=0, and resume from the held state when en returns to 1.
REQ-023 SHALL register hsync, vsync and video_on from the next-state values of x and y so they are exactly aligned with the x and y outputs (zero skew, no extra pipeline stage).
REQ-024 SHALL assert hsync active iff H_DISPLAY+H_FRONT <= x <= H_DISPLAY+H_FRONT+H_SYNC-1; vsync SHALL follow the same rule with the vertical parameters and y.
REQ-025 SHALL drive video_on = (x < H_DISPLAY) && (y < V_DISPLAY).
REQ-026 SHALL pulse line_start for the one clk with p_tick=1 and x=H_TOTAL-1; frame_start SHALL pulse in the same clk only if y=V_TOTAL-1 as well (it marks the next pixel (0,0)).
REQ-027 SHALL produce a period of exactly H_TOTAL*V_TOTAL*CLK_DIV clk cycles per frame when en=1 continuously.

Reset
REQ-028 SHALL, in the clk edge where reset=1 (regardless of en), set the divider, x and y to 0, video_on to 1, hsync and vsync to their inactive levels (~HSYNC_POL, ~VSYNC_POL), and p_tick, line_start and frame_start to 0.
REQ-029 SHALL let reset asserted mid-line or mid-frame abort the scan immediately; the first p_tick after release SHALL occur CLK_DIV clks after the first en=1 clk.

Verification
REQ-030 SHALL cover small timing (H 4/1/2/1, V 3/1/1/1, CLK_DIV=2): hsync low exactly for x=5..6, vsync low for y=4, frame period = 96 clk.
REQ-031 SHALL cover the default 640x480, CLK_DIV=2 case: frame period = 800*525*2 = 840000 clk, video_on high for 640*480 pixels per frame.
REQ-032 SHALL cover HSYNC_POL=1, VSYNC_POL=1: sync outputs high only in the sync regions and low after reset.
REQ-033 SHALL cover en toggled low for 7 clk mid-line at x=3: x, y and the divider hold, and the frame period grows by exactly 7 clk.
REQ-034 SHALL cover reset pulsed at x=6, y=2: the next clk shows x=0, y=0, video_on=1 and syncs inactive; line_start and frame_start pulse once at the correct wrap points.
REQ-035 SHALL cover CLK_DIV=1: p_tick equals en, x increments every clk, and frame period = H_TOTAL*V_TOTAL.
